instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction register. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned word is presented on IRDataOut with a one-cycle IRInEn load strobe for the instruction register. It also handles controller branch redirects, including in-flight fetch discard, and a bounded memory-wait timeout.

---
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage feeding the instruction register. Holds
//            the program counter, issues word reads to instruction memory over
//            a req/ack handshake, presents each returned word with a one-cycle
//            IR load strobe, handles branch redirects (discarding an in-flight
//            read that memory cannot abort) and raises a sticky error when
//            memory fails to answer within TimeoutCycles.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            FetchEn                 - request next instruction (IDLE only)
//            BranchEn, BranchAddr    - redirect PC, accepted in any state
//            MemReadReq, MemAddr     - read request / registered word address
//            MemAck, MemDataIn       - memory completion and returned word
//            IRDataOut, IRInEn       - fetched word and its IR load strobe
//            PCOut                   - address of the word on IRDataOut
//            FetchBusy, FetchErr     - not-idle flag, sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                 DataWidth     = 32,
    parameter int                 AddrWidth     = 24,
    parameter logic [AddrWidth-1:0] ResetVector = '0,
    parameter int                 TimeoutCycles = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 FetchEn,
    input  logic                 BranchEn,
    input  logic [AddrWidth-1:0] BranchAddr,
    output logic                 MemReadReq,
    output logic [AddrWidth-1:0] MemAddr,
    input  logic                 MemAck,
    input  logic [DataWidth-1:0] MemDataIn,
    output logic [DataWidth-1:0] IRDataOut,
    output logic                 IRInEn,
    output logic [AddrWidth-1:0] PCOut,
    output logic                 FetchBusy,
    output logic                 FetchErr
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;

    // Counter only needs to reach TimeoutCycles-1; the final no-ack cycle is
    // detected by comparison rather than by counting one past it.
    localparam int                  c_CNT_W    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TimeoutCycles - 1);

    logic [1:0]           r_state;
    logic [AddrWidth-1:0] r_pc;
    logic [AddrWidth-1:0] r_mem_addr;
    logic [DataWidth-1:0] r_ir_data;
    logic [AddrWidth-1:0] r_pc_out;
    logic                 r_fetch_err;
    logic                 r_discard;
    logic [c_CNT_W-1:0]   r_wait_cnt;

    logic [AddrWidth-1:0] w_redirect;
    logic                 w_timeout;

    // Address for a newly issued read: a same-cycle branch takes precedence
    // over the held PC (fetch issue in IDLE and re-issue after a discard).
    assign w_redirect = BranchEn ? BranchAddr : r_pc;
    assign w_timeout  = (r_wait_cnt == c_CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_pc        <= ResetVector;
            r_mem_addr  <= ResetVector;
            r_ir_data   <= '0;
            r_pc_out    <= '0;
            r_fetch_err <= 1'b0;
            r_discard   <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (BranchEn) begin
                        r_pc <= BranchAddr;
                    end
                    if (FetchEn) begin
                        r_mem_addr <= w_redirect;
                        r_wait_cnt <= '0;
                        r_state    <= c_REQ;
                    end
                end

                c_REQ: begin
                    if (MemAck) begin
                        if (r_discard || BranchEn) begin
                            // Stale word: drop it and immediately re-request
                            // from the redirected address.
                            r_mem_addr <= w_redirect;
                            r_pc       <= w_redirect;
                            r_discard  <= 1'b0;
                            r_wait_cnt <= '0;
                        end else begin
                            r_ir_data <= MemDataIn;
                            r_pc_out  <= r_mem_addr;
                            r_pc      <= r_mem_addr + AddrWidth'(1);
                            r_state   <= c_LOAD;
                        end
                    end else begin
                        if (BranchEn) begin
                            r_pc <= BranchAddr;
                        end
                        if (w_timeout) begin
                            r_fetch_err <= 1'b1;
                            r_discard   <= 1'b0;
                            r_state     <= c_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                            // Memory cannot abort, so the outstanding read
                            // keeps its address and its data is marked stale.
                            if (BranchEn) begin
                                r_discard <= 1'b1;
                            end
                        end
                    end
                end

                c_LOAD: begin
                    if (BranchEn) begin
                        r_pc <= BranchAddr;
                    end
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign MemReadReq = (r_state == c_REQ);
    assign IRInEn     = (r_state == c_LOAD);
    assign FetchBusy  = (r_state != c_IDLE);
    assign MemAddr    = r_mem_addr;
    assign IRDataOut  = r_ir_data;
    assign PCOut      = r_pc_out;
    assign FetchErr   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A transaction-level model
//            tracks the expected outputs and is compared against the design
//            on every falling edge; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int c_DW      = 32;
    localparam int c_AW      = 24;
    localparam int c_TIMEOUT = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            FetchEn = 1'b0;
    logic            BranchEn = 1'b0;
    logic [c_AW-1:0] BranchAddr = '0;
    logic            MemReadReq;
    logic [c_AW-1:0] MemAddr;
    logic            MemAck = 1'b0;
    logic [c_DW-1:0] MemDataIn = '0;
    logic [c_DW-1:0] IRDataOut;
    logic            IRInEn;
    logic [c_AW-1:0] PCOut;
    logic            FetchBusy;
    logic            FetchErr;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch #(
        .DataWidth    (c_DW),
        .AddrWidth    (c_AW),
        .ResetVector  (24'h00_0000),
        .TimeoutCycles(c_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .FetchEn   (FetchEn),
        .BranchEn  (BranchEn),
        .BranchAddr(BranchAddr),
        .MemReadReq(MemReadReq),
        .MemAddr   (MemAddr),
        .MemAck    (MemAck),
        .MemDataIn (MemDataIn),
        .IRDataOut (IRDataOut),
        .IRInEn    (IRInEn),
        .PCOut     (PCOut),
        .FetchBusy (FetchBusy),
        .FetchErr  (FetchErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Transaction model: "outstanding read", "word being delivered",
    // "stale read", number of unanswered cycles, and the program counter.
    // ------------------------------------------------------------------
    bit            m_valid = 0;
    bit            m_outstanding, m_delivering, m_stale, m_err;
    int            m_waits;
    logic [c_AW-1:0] m_pc, m_addr, m_pcout;
    logic [c_DW-1:0] m_word;

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1; m_outstanding = 0; m_delivering = 0; m_stale = 0; m_err = 0;
            m_waits = 0; m_pc = '0; m_addr = '0; m_pcout = '0; m_word = '0;
        end else if (m_valid) begin
            if (m_delivering) begin
                m_delivering = 0;
                if (BranchEn) m_pc = BranchAddr;
            end else if (!m_outstanding) begin
                if (BranchEn) m_pc = BranchAddr;
                if (FetchEn) begin
                    m_addr = m_pc; m_outstanding = 1; m_waits = 0;
                end
            end else if (MemAck) begin
                if (m_stale || BranchEn) begin
                    if (BranchEn) m_pc = BranchAddr;
                    m_addr = m_pc; m_stale = 0; m_waits = 0;
                end else begin
                    m_word = MemDataIn; m_pcout = m_addr;
                    m_pc = (m_addr + 1) % (1 << c_AW);
                    m_outstanding = 0; m_delivering = 1;
                end
            end else begin
                m_waits++;
                if (BranchEn) m_pc = BranchAddr;
                if (m_waits >= c_TIMEOUT) begin
                    m_err = 1; m_stale = 0; m_outstanding = 0;
                end else if (BranchEn) begin
                    m_stale = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("MemReadReq", 32'(MemReadReq), 32'(m_outstanding));
            chk("MemAddr",    32'(MemAddr),    32'(m_addr));
            chk("IRInEn",     32'(IRInEn),     32'(m_delivering));
            chk("IRDataOut",  IRDataOut,       m_word);
            chk("PCOut",      32'(PCOut),      32'(m_pcout));
            chk("FetchBusy",  32'(FetchBusy),  32'(m_outstanding || m_delivering));
            chk("FetchErr",   32'(FetchErr),   32'(m_err));
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue a fetch, wait `waits` unanswered cycles, then ack with `data`.
    // Leaves the bench in the LOAD cycle.
    task automatic fetch(input logic [c_DW-1:0] data, input int waits);
        FetchEn = 1; tick; FetchEn = 0;
        for (int i = 0; i < waits; i++) tick;
        MemAck = 1; MemDataIn = data; tick; MemAck = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; tick; tick; reset = 0;
        chk("rst_req", 32'(MemReadReq), 32'd0);
        chk("rst_ir",  IRDataOut, 32'd0);
        chk("rst_err", 32'(FetchErr), 32'd0);

        // 1: zero-wait fetch
        FetchEn = 1; tick; FetchEn = 0;
        chk("t1_req",  32'(MemReadReq), 32'd1);
        chk("t1_addr", 32'(MemAddr), 32'h000000);
        MemAck = 1; MemDataIn = 32'h1A00_0123; tick; MemAck = 0;
        chk("t1_load", 32'(IRInEn), 32'd1);
        chk("t1_ir",   IRDataOut, 32'h1A00_0123);
        chk("t1_pc",   32'(PCOut), 32'h000000);
        tick;
        chk("t1_load_once", 32'(IRInEn), 32'd0);

        // 2: three wait cycles
        FetchEn = 1; tick; FetchEn = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req",  32'(MemReadReq), 32'd1);
            chk("t2_addr", 32'(MemAddr), 32'h000001);
            tick;
        end
        chk("t2_req4", 32'(MemReadReq), 32'd1);
        MemAck = 1; MemDataIn = 32'h0000_0042; tick; MemAck = 0;
        chk("t2_load", 32'(IRInEn), 32'd1);
        chk("t2_pc",   32'(PCOut), 32'h000001);
        tick;
        chk("t2_load_once", 32'(IRInEn), 32'd0);

        // 3: branch while a read is outstanding
        FetchEn = 1; tick; FetchEn = 0;
        tick;
        BranchEn = 1; BranchAddr = 24'h000100; tick; BranchEn = 0;
        chk("t3_addr_held", 32'(MemAddr), 32'h000002);
        MemAck = 1; MemDataIn = 32'hDEAD_BEEF; tick; MemAck = 0;
        chk("t3_drop",  32'(IRInEn), 32'd0);
        chk("t3_req",   32'(MemReadReq), 32'd1);
        chk("t3_raddr", 32'(MemAddr), 32'h000100);
        MemAck = 1; MemDataIn = 32'h0200_0005; tick; MemAck = 0;
        chk("t3_load", 32'(IRInEn), 32'd1);
        chk("t3_ir",   IRDataOut, 32'h0200_0005);
        chk("t3_pc",   32'(PCOut), 32'h000100);
        tick;

        // 4: PC wrap
        BranchEn = 1; BranchAddr = 24'hFFFFFF; tick; BranchEn = 0;
        fetch(32'h1111_1111, 0);
        chk("t4_pc_top", 32'(PCOut), 32'hFFFFFF);
        tick;
        FetchEn = 1; tick; FetchEn = 0;
        chk("t4_wrap_addr", 32'(MemAddr), 32'h000000);
        MemAck = 1; MemDataIn = 32'h2222_2222; tick; MemAck = 0;
        chk("t4_pc_wrap", 32'(PCOut), 32'h000000);
        tick;

        // FetchEn together with BranchEn issues from the branch target
        BranchEn = 1; BranchAddr = 24'h00ABCD; FetchEn = 1; tick;
        BranchEn = 0; FetchEn = 0;
        chk("both_addr", 32'(MemAddr), 32'h00ABCD);
        MemAck = 1; MemDataIn = 32'h3333_3333; tick; MemAck = 0;
        chk("both_pc", 32'(PCOut), 32'h00ABCD);
        tick;

        // 5: timeout
        FetchEn = 1; tick; FetchEn = 0;
        for (int i = 1; i < c_TIMEOUT; i++) tick;
        chk("t5_req16", 32'(MemReadReq), 32'd1);
        chk("t5_noerr", 32'(FetchErr), 32'd0);
        tick;
        chk("t5_req17", 32'(MemReadReq), 32'd0);
        chk("t5_err",   32'(FetchErr), 32'd1);
        fetch(32'h4444_4444, 1);
        chk("t5_after_ir",  IRDataOut, 32'h4444_4444);
        chk("t5_after_pc",  32'(PCOut), 32'h00ABCE);
        chk("t5_sticky",    32'(FetchErr), 32'd1);
        tick;

        // 6: reset during an acknowledged request
        FetchEn = 1; tick; FetchEn = 0;
        tick;
        reset = 1; MemAck = 1; MemDataIn = 32'h5555_5555; tick;
        reset = 0; MemAck = 0;
        chk("t6_req",  32'(MemReadReq), 32'd0);
        chk("t6_load", 32'(IRInEn), 32'd0);
        chk("t6_ir",   IRDataOut, 32'd0);
        chk("t6_err",  32'(FetchErr), 32'd0);
        FetchEn = 1; tick; FetchEn = 0;
        chk("t6_pc_reset", 32'(MemAddr), 32'h000000);

        // Ack in the final allowed cycle wins over the timeout
        for (int i = 1; i < c_TIMEOUT; i++) tick;
        MemAck = 1; MemDataIn = 32'h6666_6666; tick; MemAck = 0;
        chk("late_ack_load", 32'(IRInEn), 32'd1);
        chk("late_ack_err",  32'(FetchErr), 32'd0);
        tick; tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
